ewb_mem_ctrl: RTL and testbench
===============================

# ewb_mem_ctrl

Memory-side controller for the L2 eviction write buffer (EWB). It owns the single physical memory port and arbitrates it between L2 miss fills (reads) and EWB drains (dirty-line write-backs). It also services L2 reads that hit a line still queued in the EWB, which keeps read-after-evict coherent. It sits between the L2 cache/EWB pair and physical memory.

## Interface
- WIDTH, 256, cache line width in bits
- COUNT_W, 7, width of the EWB occupancy count (EWB capacity 64)
- HIGH_WATER, 48, occupancy at or above which drains take priority over fills
- DRAIN_IDLE, 4, consecutive idle cycles before an opportunistic drain

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- l2_read_i  in  1  L2 line read request; held until l2_resp_o
- l2_addr_i  in  32  L2 read address
- l2_rdata_o  out  WIDTH  read line, valid with l2_resp_o
- l2_resp_o  out  1  one-cycle read completion pulse
- ewb_empty_i  in  1  EWB empty
- ewb_full_i  in  1  EWB full
- ewb_count_i  in  COUNT_W  EWB occupancy
- ewb_data_i  in  WIDTH  EWB front-entry data
- ewb_addr_i  in  32  EWB front-entry address
- ewb_yumi_o  out  1  dequeue EWB front entry (one-cycle pulse)
- ewb_tag_check_o  out  1  request EWB associative lookup
- ewb_tag_o  out  27  lookup tag, equal to l2_addr_i[31:5]
- ewb_hit_i  in  1  lookup hit (combinational)
- ewb_read_i  in  WIDTH  hit line data (combinational)
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  WIDTH  memory write data
- mem_rdata_i  in  WIDTH  memory read data
- mem_resp_i  in  1  memory completion, one cycle

## Operation
- The FSM has four states: IDLE, FILL, DRAIN, RESP. Registers: addr_q[31:0], data_q[WIDTH-1:0], idle_cnt (saturates at DRAIN_IDLE), read_owed.
- ewb_tag_check_o = (state==IDLE) & l2_read_i. It is 0 in all other states.
- IDLE transitions use the first matching rule:
  1. l2_read_i & ewb_hit_i: data_q <= ewb_read_i; go to RESP.
  2. Forced drain: !ewb_empty_i & (ewb_full_i | (ewb_count_i >= HIGH_WATER & !(l2_read_i & read_owed))). Latch addr_q/data_q from ewb_addr_i/ewb_data_i; go to DRAIN.
  3. l2_read_i (miss): addr_q <= l2_addr_i; go to FILL.
  4. Opportunistic drain: !ewb_empty_i & idle_cnt==DRAIN_IDLE. Latch front entry; go to DRAIN.
- idle_cnt increments in IDLE when l2_read_i=0 and !ewb_empty_i. It clears on any other IDLE cycle and on leaving IDLE.
- read_owed is set when a forced drain is taken while l2_read_i=1. It clears when FILL is entered. Effect: after a forced drain, a pending miss gets one fill before the next non-full forced drain. When ewb_full_i=1, a drain still wins regardless of read_owed.
- DRAIN:
  - Outputs: mem_write_o=1, mem_addr_o=addr_q, mem_wdata_o=data_q.
  - On mem_resp_i: ewb_yumi_o=1 in that same cycle, then go to IDLE.
  - The EWB front entry stays valid for lookups until yumi, so a read of a draining line hits after the drain completes.
- FILL:
  - Outputs: mem_read_o=1, mem_addr_o=addr_q.
  - On mem_resp_i: data_q <= mem_rdata_i, then go to RESP.
- RESP: l2_resp_o=1, l2_rdata_o=data_q. Next state is IDLE unconditionally; l2_read_i is ignored in this cycle.
- When not in the state that drives them, mem_addr_o and mem_wdata_o = 0 and l2_rdata_o = 0.

## Timing
- Reset (asynchronous): state=IDLE, idle_cnt=0, read_owed=0, addr_q=0, data_q=0. Every output is 0 in reset.
- Reset mid-FILL or mid-DRAIN abandons the transaction. No yumi or resp is issued for it, and the EWB entry is not dequeued.
- EWB hit latency: request seen in IDLE at cycle 0, l2_resp_o at cycle 1.
- Fill latency: FILL is entered at cycle 1. If mem_resp_i arrives at cycle k, l2_resp_o is asserted at cycle k+1.
- Drain: mem_write_o stays high from DRAIN entry through the mem_resp_i cycle. ewb_yumi_o is asserted in exactly the mem_resp_i cycle.
- mem_read_o and mem_write_o are never high together. Each strobe stays high until mem_resp_i.
- mem_resp_i outside FILL/DRAIN is ignored.
- Opportunistic drain: with the EWB nonempty and no reads, DRAIN is entered on cycle DRAIN_IDLE+1 after entering IDLE.

## Test plan
- Read miss, EWB empty, memory responds 3 cycles after strobe: l2_addr_i=0x1000_0040 → mem_read_o with mem_addr_o=0x1000_0040. l2_resp_o is 1 cycle after mem_resp_i, with l2_rdata_o=mem_rdata_i. No yumi.
- EWB hit: EWB holds line 0x2000_0020 with data D; L2 reads 0x2000_0020 → ewb_tag_o=0x1000001 (0x2000_0020 >> 5). l2_resp_o at cycle 1 with data D. No memory strobe.
- Opportunistic drain: enqueue 1 line, no reads. DRAIN is entered after 4 idle cycles, with mem_write_o, mem_addr_o and mem_wdata_o equal to the front entry. ewb_yumi_o pulses with mem_resp_i, and the EWB becomes empty.
- High-water fairness: ewb_count_i=50, read miss pending → one drain, then one fill (read_owed), then another drain. With ewb_full_i=1, two back-to-back drains precede the fill.
- Simultaneous: read miss arrives in the same cycle idle_cnt==DRAIN_IDLE, count below HIGH_WATER → FILL wins.
- Reset asserted mid-DRAIN: outputs drop to 0 immediately, no yumi, and ewb_count_i is unchanged. After release, the same entry drains again.

Source files
------------

// File: rtl/ewb_mem_ctrl.sv
// Memory-port controller for the L2 eviction write buffer: arbitrates L2 miss fills
// against EWB drains and answers L2 reads that hit a line still queued in the EWB.
module ewb_mem_ctrl #(
    parameter int WIDTH      = 256,
    parameter int COUNT_W    = 7,
    parameter int HIGH_WATER = 48,
    parameter int DRAIN_IDLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               l2_read_i,
    input  logic [31:0]        l2_addr_i,
    output logic [WIDTH-1:0]   l2_rdata_o,
    output logic               l2_resp_o,
    input  logic               ewb_empty_i,
    input  logic               ewb_full_i,
    input  logic [COUNT_W-1:0] ewb_count_i,
    input  logic [WIDTH-1:0]   ewb_data_i,
    input  logic [31:0]        ewb_addr_i,
    output logic               ewb_yumi_o,
    output logic               ewb_tag_check_o,
    output logic [26:0]        ewb_tag_o,
    input  logic               ewb_hit_i,
    input  logic [WIDTH-1:0]   ewb_read_i,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    input  logic [WIDTH-1:0]   mem_rdata_i,
    input  logic               mem_resp_i
);

    localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [31:0]        addr_q;
    logic [WIDTH-1:0]   data_q;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               read_owed;

    logic hit_take;
    logic high_water;
    logic forced_drain;
    logic opp_drain;

    assign hit_take   = l2_read_i & ewb_hit_i;
    assign high_water = (ewb_count_i >= COUNT_W'(HIGH_WATER));
    // A pending miss that was already bypassed once blocks a non-full forced drain.
    assign forced_drain = ~ewb_empty_i &
                          (ewb_full_i | (high_water & ~(l2_read_i & read_owed)));
    assign opp_drain  = ~ewb_empty_i & (idle_cnt == IDLE_W'(DRAIN_IDLE));

    // Memory/L2 strobes decode from registered state only; EWB handshakes are gated off in reset.
    assign mem_read_o      = (state == FILL);
    assign mem_write_o     = (state == DRAIN);
    assign mem_addr_o      = ((state == FILL) || (state == DRAIN)) ? addr_q : 32'd0;
    assign mem_wdata_o     = (state == DRAIN) ? data_q : {WIDTH{1'b0}};
    assign l2_resp_o       = (state == RESP);
    assign l2_rdata_o      = (state == RESP) ? data_q : {WIDTH{1'b0}};
    assign ewb_tag_check_o = ~rst & (state == IDLE) & l2_read_i;
    assign ewb_tag_o       = rst ? 27'd0 : l2_addr_i[31:5];
    assign ewb_yumi_o      = ~rst & (state == DRAIN) & mem_resp_i;

    // Arbitration FSM with its datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= 32'd0;
            data_q    <= {WIDTH{1'b0}};
            idle_cnt  <= {IDLE_W{1'b0}};
            read_owed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_take) begin
                        data_q   <= ewb_read_i;
                        idle_cnt <= {IDLE_W{1'b0}};
                        state    <= RESP;
                    end else if (forced_drain) begin
                        addr_q   <= ewb_addr_i;
                        data_q   <= ewb_data_i;
                        idle_cnt <= {IDLE_W{1'b0}};
                        if (l2_read_i) begin
                            read_owed <= 1'b1;
                        end
                        state    <= DRAIN;
                    end else if (l2_read_i) begin
                        addr_q    <= l2_addr_i;
                        idle_cnt  <= {IDLE_W{1'b0}};
                        read_owed <= 1'b0;
                        state     <= FILL;
                    end else if (opp_drain) begin
                        addr_q   <= ewb_addr_i;
                        data_q   <= ewb_data_i;
                        idle_cnt <= {IDLE_W{1'b0}};
                        state    <= DRAIN;
                    end else if (!ewb_empty_i) begin
                        if (idle_cnt != IDLE_W'(DRAIN_IDLE)) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt <= {IDLE_W{1'b0}};
                    end
                end
                FILL: begin
                    if (mem_resp_i) begin
                        data_q <= mem_rdata_i;
                        state  <= RESP;
                    end
                end
                DRAIN: begin
                    if (mem_resp_i) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ewb_mem_ctrl.sv
// Directed bench for ewb_mem_ctrl: a queue-based EWB and fixed-latency memory model,
// an expected-transaction scoreboard checked every cycle, plus literal latency checks.
module tb_ewb_mem_ctrl;

    localparam int W = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          l2_read;
    logic [31:0]   l2_addr;
    logic [W-1:0]  l2_rdata;
    logic          l2_resp;
    logic          ewb_empty, ewb_full;
    logic [6:0]    ewb_count;
    logic [W-1:0]  ewb_data;
    logic [31:0]   ewb_addr;
    logic          ewb_yumi, ewb_tag_check;
    logic [26:0]   ewb_tag;
    logic          ewb_hit;
    logic [W-1:0]  ewb_read;
    logic          mem_read, mem_write;
    logic [31:0]   mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    ewb_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .l2_read_i(l2_read), .l2_addr_i(l2_addr), .l2_rdata_o(l2_rdata), .l2_resp_o(l2_resp),
        .ewb_empty_i(ewb_empty), .ewb_full_i(ewb_full), .ewb_count_i(ewb_count),
        .ewb_data_i(ewb_data), .ewb_addr_i(ewb_addr), .ewb_yumi_o(ewb_yumi),
        .ewb_tag_check_o(ewb_tag_check), .ewb_tag_o(ewb_tag),
        .ewb_hit_i(ewb_hit), .ewb_read_i(ewb_read),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
    );

    // EWB model: FIFO of lines, entry 0 is the front.
    logic [31:0]  ea [8];
    logic [W-1:0] ed [8];
    int en = 0, bias = 0, full_thr = 8;

    assign ewb_empty = (en == 0);
    assign ewb_full  = (en >= full_thr);
    assign ewb_count = 7'(en + bias);
    assign ewb_addr  = ea[0];
    assign ewb_data  = ed[0];

    always_comb begin
        ewb_hit  = 1'b0;
        ewb_read = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < en && ea[i][31:5] == l2_addr[31:5]) begin
                ewb_hit  = 1'b1;
                ewb_read = ed[i];
            end
        end
    end

    typedef struct {
        bit           wr;
        logic [31:0]  a;
        logic [W-1:0] d;
    } op_t;

    op_t          exp_q[$];
    logic [W-1:0] resp_q[$];
    op_t          cur;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, prev_kind = 0, age = 0, lat = 3;
    int ev_resp = -1, ev_yumi = -1, ev_fill = -1, ev_drain = -1;
    bit next_resp = 0, stray = 0;
    logic [W-1:0] rd_data = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_ewb(input logic [31:0] a, input logic [W-1:0] d);
        ea[en] = a;
        ed[en] = d;
        en++;
    endtask

    task automatic expect_op(input bit wr, input logic [31:0] a, input logic [W-1:0] d);
        op_t o;
        o.wr = wr; o.a = a; o.d = d;
        exp_q.push_back(o);
    endtask

    // One clock: check outputs at the falling edge, then advance the models after the rising edge.
    task automatic step();
        int  kind;
        bit  do_deq, drop;
        @(negedge clk);
        kind = mem_write ? 2 : (mem_read ? 1 : 0);
        if (rst) begin
            chk("rst_strobes", {mem_read, mem_write, l2_resp, ewb_yumi, ewb_tag_check}, '0);
            chk("rst_addr", mem_addr, '0);
            chk("rst_wdata", mem_wdata, '0);
            chk("rst_rdata", l2_rdata, '0);
            chk("rst_tag", ewb_tag, '0);
        end else begin
            chk("excl", mem_read & mem_write, 1'b0);
            chk("yumi", ewb_yumi, mem_write & mem_resp);
            chk("tag_check", ewb_tag_check, l2_read & ~(mem_read | mem_write | l2_resp));
            chk("tag", ewb_tag, l2_addr[31:5]);
            if (kind == 0) chk("addr_idle", mem_addr, '0);
            if (!mem_write) chk("wdata_idle", mem_wdata, '0);
            if (!l2_resp) chk("rdata_idle", l2_rdata, '0);
            if (kind != 0 && kind != prev_kind) begin
                if (kind == 1) ev_fill = cyc; else ev_drain = cyc;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_op: got kind %0d addr %0h, required none", kind, mem_addr);
                    cur.wr = (kind == 2); cur.a = mem_addr; cur.d = mem_wdata;
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (kind != 0) begin
                chk("op_kind", (kind == 2), cur.wr);
                chk("op_addr", mem_addr, cur.a);
                if (kind == 2) chk("op_wdata", mem_wdata, cur.d);
            end
            if (l2_resp) begin
                ev_resp = cyc;
                if (resp_q.size() == 0) chk("unexpected_resp", l2_resp, 1'b0);
                else chk("resp_data", l2_rdata, resp_q.pop_front());
            end
            if (ewb_yumi) ev_yumi = cyc;
        end
        prev_kind = rst ? 0 : kind;
        if (rst || kind == 0 || mem_resp) begin
            age = 0;
            next_resp = 0;
        end else begin
            age++;
            next_resp = (age >= lat);
        end
        do_deq = ewb_yumi && !rst;
        drop   = l2_resp && !rst;
        cyc++;
        @(posedge clk);
        #1;
        if (do_deq) begin
            for (int i = 0; i < 7; i++) begin
                ea[i] = ea[i+1];
                ed[i] = ed[i+1];
            end
            en--;
        end
        if (drop) l2_read = 1'b0;
        mem_resp  = next_resp | stray;
        stray     = 0;
        mem_rdata = rd_data;
    endtask

    function automatic int ev_of(input int which);
        case (which)
            0: return ev_resp;
            1: return ev_yumi;
            2: return ev_fill;
            default: return ev_drain;
        endcase
    endfunction

    // which: 0 resp, 1 yumi, 2 fill start, 3 drain start
    task automatic wait_for(input string name, input int which, input int max);
        int mark = cyc;
        for (int i = 0; i < max; i++) begin
            step();
            if (ev_of(which) >= mark) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: timeout after %0d cycles, required event %0d", name, max, which);
    endtask

    task automatic wait_quiet(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (exp_q.size() == 0 && resp_q.size() == 0 && !mem_read && !mem_write && !l2_resp)
                return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: timeout after %0d cycles, %0d ops pending", name, max, exp_q.size());
    endtask

    int c0;

    initial begin
        rst = 1'b1; l2_read = 1'b1; l2_addr = 32'hDEAD_BEE0; mem_resp = 1'b1; mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin ea[i] = '0; ed[i] = '0; end
        step(); step();
        rst = 1'b0; l2_read = 1'b0; mem_resp = 1'b0;
        step();

        // Read miss, EWB empty
        rd_data = {8{32'hA5A5_0001}};
        l2_addr = 32'h1000_0040; l2_read = 1'b1;
        expect_op(1'b0, 32'h1000_0040, '0);
        resp_q.push_back({8{32'hA5A5_0001}});
        c0 = cyc;
        wait_for("t1_resp", 0, 20);
        chk("t1_fill_lat", ev_fill - c0, 1);
        chk("t1_resp_lat", ev_resp - c0, 5);
        chk("t1_no_yumi", ev_yumi >= c0, 1'b0);

        // Stray memory response while idle
        c0 = cyc;
        stray = 1;
        step(); step(); step();
        chk("stray_no_resp", ev_resp >= c0, 1'b0);

        // EWB hit, then the same line drains opportunistically
        push_ewb(32'h2000_0020, {8{32'hD00D_0020}});
        l2_addr = 32'h2000_0020; l2_read = 1'b1;
        resp_q.push_back({8{32'hD00D_0020}});
        expect_op(1'b1, 32'h2000_0020, {8{32'hD00D_0020}});
        #1;
        chk("t2_tag", ewb_tag, 27'h100_0001);
        chk("t2_tag_check", ewb_tag_check, 1'b1);
        c0 = cyc;
        wait_for("t2_resp", 0, 10);
        chk("t2_resp_lat", ev_resp - c0, 1);
        chk("t2_no_fill", ev_fill >= c0, 1'b0);
        wait_for("t2_yumi", 1, 30);
        chk("t2_drain_lat", ev_drain - c0, 7);
        chk("t2_empty", en, 0);

        // Opportunistic drain of one queued line
        step(); step();
        push_ewb(32'h3000_0100, {8{32'h0BAD_F00D}});
        expect_op(1'b1, 32'h3000_0100, {8{32'h0BAD_F00D}});
        c0 = cyc;
        wait_for("t3_yumi", 1, 30);
        chk("t3_drain_lat", ev_drain - c0, 5);
        chk("t3_yumi_lat", ev_yumi - c0, 8);
        chk("t3_empty", en, 0);

        // Read miss in the same cycle idle_cnt reaches DRAIN_IDLE: fill wins
        step();
        push_ewb(32'h4000_0080, {8{32'h1234_5678}});
        rd_data = {8{32'hCAFE_0005}};
        expect_op(1'b0, 32'h5000_0000, '0);
        expect_op(1'b1, 32'h4000_0080, {8{32'h1234_5678}});
        resp_q.push_back({8{32'hCAFE_0005}});
        c0 = cyc;
        step(); step(); step(); step();
        l2_addr = 32'h5000_0000; l2_read = 1'b1;
        wait_for("t5_resp", 0, 20);
        chk("t5_fill_lat", ev_fill - c0, 5);
        wait_for("t5_yumi", 1, 30);
        chk("t5_drain_after", ev_drain - ev_resp, 6);

        // High-water fairness: drain, fill, drain, drain
        bias = 47;
        push_ewb(32'h6000_0000, {8{32'hAAAA_0000}});
        push_ewb(32'h6000_0020, {8{32'hBBBB_0000}});
        push_ewb(32'h6000_0040, {8{32'hCCCC_0000}});
        rd_data = {8{32'h7777_0000}};
        expect_op(1'b1, 32'h6000_0000, {8{32'hAAAA_0000}});
        expect_op(1'b0, 32'h7000_0000, '0);
        expect_op(1'b1, 32'h6000_0020, {8{32'hBBBB_0000}});
        expect_op(1'b1, 32'h6000_0040, {8{32'hCCCC_0000}});
        resp_q.push_back({8{32'h7777_0000}});
        l2_addr = 32'h7000_0000; l2_read = 1'b1;
        wait_quiet("t4_fair", 100);
        chk("t4_empty", en, 0);

        // Full EWB: two drains before the owed fill
        full_thr = 2;
        push_ewb(32'h6100_0000, {8{32'h1111_0000}});
        push_ewb(32'h6100_0020, {8{32'h2222_0000}});
        push_ewb(32'h6100_0040, {8{32'h3333_0000}});
        rd_data = {8{32'h8888_0000}};
        expect_op(1'b1, 32'h6100_0000, {8{32'h1111_0000}});
        expect_op(1'b1, 32'h6100_0020, {8{32'h2222_0000}});
        expect_op(1'b0, 32'h7100_0000, '0);
        expect_op(1'b1, 32'h6100_0040, {8{32'h3333_0000}});
        resp_q.push_back({8{32'h8888_0000}});
        l2_addr = 32'h7100_0000; l2_read = 1'b1;
        wait_quiet("t4_full", 100);
        chk("t4_full_empty", en, 0);
        full_thr = 8; bias = 0;

        // Reset mid-drain abandons the write; the entry drains again afterwards
        lat = 20;
        push_ewb(32'h8000_0000, {8{32'h9999_0000}});
        expect_op(1'b1, 32'h8000_0000, {8{32'h9999_0000}});
        expect_op(1'b1, 32'h8000_0000, {8{32'h9999_0000}});
        wait_for("t6_drain", 3, 20);
        step(); step();
        rst = 1'b1;
        #1;
        chk("t6_rst_write", {mem_write, ewb_yumi}, '0);
        chk("t6_rst_addr", mem_addr, '0);
        step(); step();
        chk("t6_count", ewb_count, 7'd1);
        rst = 1'b0; lat = 3;
        c0 = cyc;
        wait_for("t6_yumi", 1, 30);
        chk("t6_redrain_lat", ev_drain - c0, 5);
        chk("t6_empty", en, 0);

        chk("queues_empty", exp_q.size() + resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
